// File: rtl/spi_slave_if_if.sv
// SPI-side and RAM-side signal bundle for the SPI slave front end.
// The master modport is the SPI master plus the RAM; the slave modport is the front end.
interface spi_slave_if_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
);
  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises MOSI frames for the RAM and
// shifts RAM read data out on MISO, one SPI bit per system clock.
module spi_slave_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_if_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [3:0] FRAME_LAST = 4'(FRAME_W - 1);
  localparam logic [3:0] FRAME_CNT  = 4'(FRAME_W);
  localparam logic [3:0] TX_LAST    = 4'(DATA_W);
  localparam logic [3:0] TX_DONE    = 4'(DATA_W + 1);

  state_t             state_reg;
  logic [3:0]         bit_cnt_reg;
  logic [FRAME_W-2:0] rx_shift_reg;
  logic [FRAME_W-1:0] rx_data_reg;
  logic               rx_valid_reg;
  logic               rd_addr_pend_reg;
  logic [DATA_W-1:0]  tx_shift_reg;
  logic [3:0]         tx_cnt_reg;
  logic               miso_reg;

  assign bus.MISO     = miso_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;

  // tx_cnt_reg: 0 = waiting for RAM data, 1..DATA_W = bits driven, TX_DONE = finished
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      bit_cnt_reg      <= '0;
      rx_shift_reg     <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rd_addr_pend_reg <= 1'b0;
      tx_shift_reg     <= '0;
      tx_cnt_reg       <= '0;
      miso_reg         <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (state_reg != IDLE && bus.SS_n) begin
        // Chip select dropped: abandon any partial frame or transmission.
        state_reg    <= IDLE;
        bit_cnt_reg  <= '0;
        rx_shift_reg <= '0;
        tx_shift_reg <= '0;
        tx_cnt_reg   <= '0;
        miso_reg     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (!bus.SS_n) state_reg <= CHK_CMD;
          end
          CHK_CMD: begin
            rx_shift_reg <= {{(FRAME_W-2){1'b0}}, bus.MOSI};
            bit_cnt_reg  <= 4'd1;
            if (!bus.MOSI)             state_reg <= WRITE;
            else if (rd_addr_pend_reg) state_reg <= READ_DATA;
            else                       state_reg <= READ_ADD;
          end
          default: begin
            if (bit_cnt_reg < FRAME_CNT) begin
              rx_shift_reg <= {rx_shift_reg[FRAME_W-3:0], bus.MOSI};
              bit_cnt_reg  <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == FRAME_LAST) begin
                rx_data_reg  <= {rx_shift_reg, bus.MOSI};
                rx_valid_reg <= 1'b1;
                if (state_reg == READ_ADD)  rd_addr_pend_reg <= 1'b1;
                if (state_reg == READ_DATA) rd_addr_pend_reg <= 1'b0;
              end
            end else if (state_reg == READ_DATA) begin
              if (tx_cnt_reg == 4'd0) begin
                if (bus.tx_valid) begin
                  miso_reg     <= bus.tx_data[DATA_W-1];
                  tx_shift_reg <= {bus.tx_data[DATA_W-2:0], 1'b0};
                  tx_cnt_reg   <= 4'd1;
                end
              end else if (tx_cnt_reg < TX_LAST) begin
                miso_reg     <= tx_shift_reg[DATA_W-1];
                tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                tx_cnt_reg   <= tx_cnt_reg + 4'd1;
              end else if (tx_cnt_reg == TX_LAST) begin
                miso_reg   <= 1'b0;
                tx_cnt_reg <= TX_DONE;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: table of SPI frames with expected RAM-side words
// and MISO bytes, checked cycle by cycle against scoreboard queues.
module tb_spi_slave_if;

  logic clk = 1'b0;
  logic rst;
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  bit   mon_en   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  spi_slave_if_if #(.FRAME_W(10), .DATA_W(8)) bus ();

  spi_slave_if #(.FRAME_W(10), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [9:0] frame;
    int         nbits;       // 10 = complete frame, fewer = SS_n abort
    int         extra;       // surplus MOSI bits clocked after the frame
    logic       do_tx;       // pulse tx_valid after the frame
    logic [7:0] tx_byte;
    int         tx_bits;     // 8 = full byte, fewer = cut short
    logic       use_rst;     // cut short with rst instead of SS_n
    logic       exp_rx;
    logic [9:0] exp_rx_data;
    logic       exp_miso;    // byte expected on MISO
  } vec_t;

  typedef struct { int edge_no; logic [9:0] data; } rx_exp_t;
  typedef struct { int edge_no; logic bit_v; } miso_exp_t;

  rx_exp_t   rx_q[$];
  miso_exp_t miso_q[$];
  vec_t      vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, edge_cnt, act, exp);
    end
  endtask

  // Every cycle: rx_valid/rx_data and MISO against the scoreboards (default 0).
  always @(negedge clk) begin
    logic       exp_v;
    logic [9:0] exp_d;
    logic       exp_m;
    if (mon_en) begin
      exp_v = 1'b0;
      exp_d = '0;
      if (rx_q.size() > 0 && rx_q[0].edge_no == edge_cnt) begin
        exp_v = 1'b1;
        exp_d = rx_q[0].data;
        void'(rx_q.pop_front());
      end
      chk("rx_valid", 32'(bus.rx_valid), 32'(exp_v));
      if (exp_v) chk("rx_data", 32'(bus.rx_data), 32'(exp_d));
      exp_m = 1'b0;
      if (miso_q.size() > 0 && miso_q[0].edge_no == edge_cnt) begin
        exp_m = miso_q[0].bit_v;
        void'(miso_q.pop_front());
      end
      chk("miso", 32'(bus.MISO), 32'(exp_m));
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    int t;
    @(negedge clk);
    bus.SS_n = 1'b0;
    n = edge_cnt + 1;
    for (int i = 9; i >= 10 - v.nbits; i--) begin
      @(negedge clk);
      bus.MOSI = v.frame[i];
    end
    if (v.nbits < 10) begin
      @(negedge clk);
      bus.SS_n = 1'b1;
      bus.MOSI = 1'b0;
      @(negedge clk);
      @(negedge clk);
      return;
    end
    if (v.exp_rx) rx_q.push_back('{n + 10, v.exp_rx_data});
    @(negedge clk);
    for (int i = 0; i < v.extra; i++) begin
      bus.MOSI = 1'($urandom_range(1));
      @(negedge clk);
    end
    if (v.do_tx) begin
      bus.tx_data  = v.tx_byte;
      bus.tx_valid = 1'b1;
      t = edge_cnt + 1;
      if (v.exp_miso)
        for (int i = 0; i < v.tx_bits; i++) miso_q.push_back('{t + i, v.tx_byte[7 - i]});
      @(negedge clk);
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
      if (v.tx_bits < 8) begin
        repeat (v.tx_bits - 1) @(negedge clk);
        if (v.use_rst) begin
          rst      = 1'b1;
          bus.SS_n = 1'b1;
          @(negedge clk);
          chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
          chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
          chk("rst_miso", 32'(bus.MISO), 32'd0);
          rst = 1'b0;
        end else begin
          bus.SS_n = 1'b1;
          @(negedge clk);
        end
        @(negedge clk);
        return;
      end
      repeat (8) @(negedge clk);
      // A late tx_valid after the byte must not restart transmission.
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      repeat (2) @(negedge clk);
    end
    bus.SS_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{10'b00_0000_0101, 10, 0, 1'b0, 8'h00, 8, 1'b0, 1'b1, 10'h005, 1'b0};
    vecs[1] = '{10'b01_1010_1010, 10, 2, 1'b0, 8'h00, 8, 1'b0, 1'b1, 10'h1AA, 1'b0};
    vecs[2] = '{10'b10_0000_0101, 10, 0, 1'b1, 8'h5A, 8, 1'b0, 1'b1, 10'h205, 1'b0};
    vecs[3] = '{10'b11_0000_0000, 10, 0, 1'b1, 8'hC3, 8, 1'b0, 1'b1, 10'h300, 1'b1};
    vecs[4] = '{10'b11_0101_0101, 10, 0, 1'b1, 8'h99, 8, 1'b0, 1'b1, 10'h355, 1'b0};
    vecs[5] = '{10'b11_1111_1111,  5, 0, 1'b0, 8'h00, 8, 1'b0, 1'b0, 10'h000, 1'b0};
    vecs[6] = '{10'b00_1111_0000, 10, 0, 1'b0, 8'h00, 8, 1'b0, 1'b1, 10'h0F0, 1'b0};
    vecs[7] = '{10'b11_0000_0001, 10, 1, 1'b1, 8'hFF, 3, 1'b0, 1'b1, 10'h301, 1'b1};
    vecs[8] = '{10'b11_0000_0010, 10, 0, 1'b1, 8'h81, 8, 1'b0, 1'b1, 10'h302, 1'b0};
    vecs[9] = '{10'b11_0000_0011, 10, 4, 1'b1, 8'h3C, 8, 1'b0, 1'b1, 10'h303, 1'b1};

    rst          = 1'b1;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(bus.MISO), 32'd0);
    chk("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset while a read byte is in flight, then confirm the flag was cleared.
    run_vec('{10'b10_0100_0000, 10, 0, 1'b0, 8'h00, 8, 1'b0, 1'b1, 10'h240, 1'b0});
    run_vec('{10'b11_1000_0000, 10, 0, 1'b1, 8'hA5, 4, 1'b1, 1'b1, 10'h380, 1'b1});
    run_vec('{10'b11_0000_0111, 10, 0, 1'b1, 8'h77, 8, 1'b0, 1'b1, 10'h307, 1'b0});
    run_vec('{10'b11_0001_0001, 10, 0, 1'b1, 8'h3C, 8, 1'b0, 1'b1, 10'h311, 1'b1});

    repeat (3) @(negedge clk);
    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    chk("miso_queue_drained", 32'(miso_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial front end of the SPI-slave/single-port-RAM subsystem, directly upstream of the RAM. It deserialises 10-bit MOSI frames into parallel words (`rx_data`, `rx_valid`) for the RAM and serialises the RAM's 8-bit read data (`tx_data`, `tx_valid`) back onto MISO. A five-state FSM tracks chip select, the command type, and whether a read address is pending. SPI bits are sampled on the system clock, one bit per cycle.

## Interface
- `FRAME_W`, 10: bits per MOSI frame (2 command + 8 address/data).
- `DATA_W`, 8: bits per MISO read-data word.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `SS_n` input 1: chip select, active-low.
- `MOSI` input 1: serial in, MSB first.
- `MISO` output 1: serial out, MSB first.
- `rx_data` output FRAME_W: assembled frame to RAM (`[9:8]` is the command).
- `rx_valid` output 1: one-cycle strobe, `rx_data` valid.
- `tx_data` input DATA_W: RAM read data.
- `tx_valid` input 1: `tx_data` valid strobe from RAM.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Internal flag `rd_addr_pend`; 4-bit bit counter; 8-bit TX shift register with 4-bit TX counter.
- IDLE: `SS_n`=0 -> CHK_CMD. Otherwise stay.
- CHK_CMD: sample `MOSI` as frame bit 9, shift it in, and set bit count to 1. `MOSI`=0 -> WRITE. `MOSI`=1 with `rd_addr_pend`=0 -> READ_ADD. `MOSI`=1 with `rd_addr_pend`=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift one `MOSI` bit per cycle until 10 bits are held. On the 10th bit, load `rx_data` and pulse `rx_valid` once. Further MOSI bits in the same frame are ignored, with no second strobe.
- `rd_addr_pend` is set when a READ_ADD frame completes and cleared when a READ_DATA frame completes. Frame bits `[8]` are passed through unchecked; the state is chosen only by bit 9 and the flag.
- READ_DATA, after its `rx_valid`: wait for `tx_valid`. On the cycle `tx_valid`=1 is sampled, load `tx_data` into the TX shift register. MISO then carries bit 7 down to bit 0 on the next 8 cycles. After bit 0, MISO returns to 0 and further `tx_valid` is ignored until the next frame.
- `tx_valid` outside this wait window is ignored.
- `SS_n`=1 in any non-IDLE state -> IDLE next cycle. On that transition:
  - clear the bit and TX counters and the shift registers;
  - discard any partial frame (no `rx_valid`);
  - force MISO to 0;
  - leave `rd_addr_pend` unchanged.
- `rst`=1, at any time including mid-frame or mid-transmit, -> IDLE, `rd_addr_pend`=0, all counters cleared.

## Timing
- Reset values: `MISO`=0, `rx_data`=0, `rx_valid`=0, state IDLE.
- Frame sequence, with `SS_n` first sampled low at edge N:
  - CHK_CMD during cycle N+1; bit 9 sampled at edge N+1.
  - Bits 8..0 sampled at edges N+2..N+10.
  - `rx_valid`=1 and `rx_data` valid during cycle N+11 only.
- `rx_data` holds its value until the next completed frame.
- Read-data return, with `tx_valid` sampled high at edge T:
  - MISO = `tx_data[7]` during cycle T+1, through `tx_data[0]` during cycle T+8.
  - With a 1-cycle RAM, T = N+12, so the MSB appears at cycle N+13.
- `SS_n` rising at edge E: state is IDLE in cycle E+1, and MISO is 0 from cycle E+1.
- `rst` and `SS_n` events in the same cycle: `rst` wins.
- All outputs are registered. `rx_valid` is never high in two consecutive cycles.

## Test plan
- Write address, then write data:
  - Frame `00_0000_0101` -> `rx_valid` one cycle at N+11, `rx_data`=0x005.
  - Next frame `01_1010_1010` -> `rx_data`=0x1AA.
  - No MISO activity in either frame.
- Read sequence:
  - Frame `10_0000_0101` -> `rx_data`=0x205, `rd_addr_pend`=1.
  - Frame `11_0000_0000` -> `rx_data`=0x300.
  - Drive `tx_data`=0xC3 with `tx_valid` pulsed one cycle later -> MISO `1,1,0,0,0,0,1,1` on the next 8 cycles, then 0.
- Read data before any read address: MOSI bit9=1 with `rd_addr_pend`=0 -> the FSM enters READ_ADD and no MISO output follows.
- Abort mid-frame: `SS_n` raised after 5 bits -> no `rx_valid`, IDLE next cycle. A following full frame `00_1111_0000` -> `rx_data`=0x0F0.
- Abort mid-transmit: `SS_n` raised after 3 MISO bits of 0xFF -> MISO=0 from the next cycle. `rd_addr_pend` remains 0.
- Reset: `rst` asserted during READ_DATA with bits in flight -> all outputs 0 the next cycle and the flag cleared. The next read-command frame enters READ_ADD.
